spi_poll_sequencer: RTL
=======================

// Module: spi_poll_sequencer
// PURPOSE
//  Transaction sequencer sitting directly upstream of SPI_Master: drives START/DATA_IN, consumes
//  VALID/DATA_OUT. Round-robins a table of NUM_REGS command words (e.g. gate-driver status reads),
//  latches each reply into a result bank, and lets the host inject one-shot write transfers
//  between polls. Detects a stalled master via timeout.
// PARAMETERS
//  DATA_BIT_WIDTH  16    word width; must equal the SPI_Master instance's DATA_BIT_WIDTH
//  NUM_REGS        4     command/result table depth (>=1)
//  GAP_CYCLES      32    idle clk cycles between transfers (>=1; SEL deassert time)
//  START_HOLD      4     clk cycles SPI_START is held high (>=2; master edge-detects via 2 flops)
//  TIMEOUT_CYCLES  1024  max clk cycles from START rise to reply capture
// PORTS
//  clk           in   1                    system clock
//  rst_n         in   1                    synchronous active-low reset
//  EN            in   1                    0: finish nothing, go IDLE immediately, START low
//  CMD_WORDS     in   NUM_REGS*W           command table, entry i at [i*W +: W], sampled at LOAD
//  WR_REQ        in   1                    level request for one write transfer
//  WR_DATA       in   W                    write word, sampled when WR_REQ is accepted
//  WR_ACK        out  1                    1-cycle pulse: write transfer complete, WR_RESP valid
//  WR_RESP       out  W                    reply word of last write transfer
//  SPI_START     out  1                    to SPI_Master START
//  SPI_DATA_IN   out  W                    to SPI_Master DATA_IN
//  SPI_BUSY      in   1                    from SPI_Master BUSY
//  SPI_VALID     in   1                    from SPI_Master VALID
//  SPI_DATA_OUT  in   W                    from SPI_Master DATA_OUT
//  RESULT_WORDS  out  NUM_REGS*W           reply for entry i at [i*W +: W]
//  RESULT_FRESH  out  NUM_REGS             bit i set on capture into entry i, cleared by SWEEP_DONE cycle+1
//  SWEEP_DONE    out  1                    1-cycle pulse after entry NUM_REGS-1 captured
//  TIMEOUT_ERR   out  1                    sticky; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, RESULT_WORDS 0, index 0, FSM IDLE. EN=0 acts as reset except TIMEOUT_ERR
//  and RESULT_WORDS hold.
//  FSM: IDLE -(EN)-> SELECT -> LOAD -> START_HI -> WAIT_BUSY -> WAIT_VALID -> GAP -> SELECT.
//  SELECT: if WR_REQ=1 the transfer is a write (latch WR_DATA), else poll CMD_WORDS[index]. 1 cycle.
//  LOAD: SPI_DATA_IN driven from latched word; held constant until GAP exits. 1 cycle.
//  START_HI: SPI_START=1 for exactly START_HOLD cycles, then 0 for remainder of transfer.
//  WAIT_BUSY: wait SPI_BUSY=1. WAIT_VALID: wait SPI_VALID 0->1 edge (VALID is registered once;
//  the edge is prev=0, cur=1); capture SPI_DATA_OUT that same cycle.
//  Capture: poll -> RESULT_WORDS[index], RESULT_FRESH[index]=1, index++ (wrap NUM_REGS-1 -> 0
//  with SWEEP_DONE pulse); write -> WR_RESP, WR_ACK pulse, index unchanged.
//  GAP: exactly GAP_CYCLES cycles, START low; WR_REQ deasserting during a write is ignored.
//  Writes have priority over polls at SELECT; the host must drop WR_REQ within 1 cycle of WR_ACK
//  or a second write is issued.
//  Timeout: a cycle counter starts at the START_HI entry; reaching TIMEOUT_CYCLES in WAIT_BUSY or
//  WAIT_VALID sets TIMEOUT_ERR, discards the transfer (no capture, no ACK, index unchanged), and
//  goes to GAP. The write is retried if WR_REQ is still high.
//  EN falling mid-transfer: START forced 0 next cycle, FSM IDLE, no capture or ACK.
//  Index arithmetic: clog2(NUM_REGS) bits, NUM_REGS=1 -> index constant 0, SWEEP_DONE every capture.
// STRUCTURE
//  Shared package spi_seq_pkg: FSM state encoding (localparams), the clog2 function for
//  index/counter widths. One sub-module: spi_seq_timer (loadable down-counter, zero flag),
//  instanced twice (gap and timeout). Result bank is an inline register array.
// TESTING (bench pairs DUT with real SPI_Master + MISO loopback model returning ~MOSI word)
//  NUM_REGS=4, CMD 0x8001..0x8004 -> RESULT words 0x7FFE..0x7FFB, SWEEP_DONE once per 4 captures
//  WR_REQ=1 WR_DATA=0x1234 mid-poll -> served after current poll, WR_RESP=0xEDCB, WR_ACK 1 cycle,
//  poll index unchanged
//  SPI_BUSY tied 0 -> TIMEOUT_ERR set after exactly TIMEOUT_CYCLES, no capture, index not advanced
//  EN dropped during WAIT_VALID -> SPI_START 0, FSM IDLE, RESULT_FRESH unchanged; EN=1 restarts at same index
//  rst_n low mid-transfer for 1 cycle -> all outputs 0 next cycle; check START high exactly START_HOLD
//  Measure GAP: SPI_START rise-to-rise = START_HOLD + transfer + GAP_CYCLES + 2, constant across sweeps

Source files
------------

// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_pkg
//  Description : Shared definitions for the SPI poll sequencer: FSM state
//                encoding and width helper functions for index/counter sizing.
//  Contents    : state_t, c_ST_* state codes, seq_clog2(), seq_width()
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE       = 3'd0;
    localparam state_t c_ST_SELECT     = 3'd1;
    localparam state_t c_ST_LOAD       = 3'd2;
    localparam state_t c_ST_START_HI   = 3'd3;
    localparam state_t c_ST_WAIT_BUSY  = 3'd4;
    localparam state_t c_ST_WAIT_VALID = 3'd5;
    localparam state_t c_ST_GAP        = 3'd6;

    // Ceiling log2: number of bits needed to count 0..value-1.
    function automatic int seq_clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    // Same as seq_clog2 but never narrower than one bit, so a depth of 1
    // still yields a legal (constant-zero) register.
    function automatic int seq_width(input int value);
        int width;
        width = seq_clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_timer
//  Description : Loadable down-counter that saturates at zero. The zero flag
//                marks the last cycle of a period loaded as (length - 1).
//  Ports       : clk, rst_n        clock, synchronous active-low reset
//                load, load_val    reload the counter (load wins over count)
//                zero              count has reached zero
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_poll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_poll_sequencer
//  Description : Sequencer upstream of an SPI master. Polls a table of command
//                words round-robin, stores each reply in a result bank, and
//                interleaves host write transfers between polls. A stalled
//                master is detected by a per-transfer timeout.
//  Ports       : clk, rst_n            clock, synchronous active-low reset
//                EN                    run enable; low parks the FSM in IDLE
//                CMD_WORDS             command table, entry i at [i*W +: W]
//                WR_REQ/WR_DATA        host write request (level) and word
//                WR_ACK/WR_RESP        write done pulse and its reply word
//                SPI_START/SPI_DATA_IN to the SPI master
//                SPI_BUSY/SPI_VALID/SPI_DATA_OUT from the SPI master
//                RESULT_WORDS          reply bank, entry i at [i*W +: W]
//                RESULT_FRESH          per-entry captured-this-sweep flags
//                SWEEP_DONE            pulse after the last entry is captured
//                TIMEOUT_ERR           sticky stalled-master flag
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_poll_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = 16,
    parameter int NUM_REGS       = 4,
    parameter int GAP_CYCLES     = 32,
    parameter int START_HOLD     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               EN,
    input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] CMD_WORDS,
    input  logic                               WR_REQ,
    input  logic [DATA_BIT_WIDTH-1:0]          WR_DATA,
    output logic                               WR_ACK,
    output logic [DATA_BIT_WIDTH-1:0]          WR_RESP,
    output logic                               SPI_START,
    output logic [DATA_BIT_WIDTH-1:0]          SPI_DATA_IN,
    input  logic                               SPI_BUSY,
    input  logic                               SPI_VALID,
    input  logic [DATA_BIT_WIDTH-1:0]          SPI_DATA_OUT,
    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] RESULT_WORDS,
    output logic [NUM_REGS-1:0]                RESULT_FRESH,
    output logic                               SWEEP_DONE,
    output logic                               TIMEOUT_ERR
);

    localparam int c_W     = DATA_BIT_WIDTH;
    localparam int c_IDX_W = seq_width(NUM_REGS);
    localparam int c_GAP_W = seq_width((GAP_CYCLES > START_HOLD) ? GAP_CYCLES : START_HOLD);
    localparam int c_TMO_W = seq_width(TIMEOUT_CYCLES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REGS - 1);

    state_t               state_q,    state_d;
    logic                 start_q,    start_d;
    logic [c_W-1:0]       data_in_q,  data_in_d;
    logic                 is_write_q, is_write_d;
    logic [c_W-1:0]       wr_word_q,  wr_word_d;
    logic [c_IDX_W-1:0]   idx_q,      idx_d;
    logic [NUM_REGS-1:0]  fresh_q,    fresh_d;
    logic [c_W-1:0]       result_q    [NUM_REGS];
    logic [c_W-1:0]       result_d    [NUM_REGS];
    logic [c_W-1:0]       wr_resp_q,  wr_resp_d;
    logic                 wr_ack_q,   wr_ack_d;
    logic                 sweep_q,    sweep_d;
    logic                 tmo_err_q,  tmo_err_d;
    logic                 valid_prev_q;

    logic [c_W-1:0]       w_cmd_word;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic                 w_valid_rise;
    logic                 w_gap_load;
    logic [c_GAP_W-1:0]   w_gap_val;
    logic                 w_gap_zero;
    logic                 w_tmo_load;
    logic                 w_tmo_zero;

    assign w_cmd_word   = CMD_WORDS[int'(idx_q) * c_W +: c_W];
    assign w_idx_next   = (idx_q == c_LAST_IDX) ? '0 : idx_q + c_IDX_W'(1);
    // SPI_VALID stays high between transfers, so only a fresh 0->1 edge is a reply.
    assign w_valid_rise = SPI_VALID & ~valid_prev_q;

    // One timer paces both the START pulse width and the inter-transfer gap;
    // the two never overlap in time.
    spi_seq_timer #(.WIDTH(c_GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_gap_load),
        .load_val (w_gap_val),
        .zero     (w_gap_zero)
    );

    spi_seq_timer #(.WIDTH(c_TMO_W)) u_tmo_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmo_load),
        .load_val (c_TMO_W'(TIMEOUT_CYCLES - 1)),
        .zero     (w_tmo_zero)
    );

    always_comb begin
        state_d    = state_q;
        data_in_d  = data_in_q;
        is_write_d = is_write_q;
        wr_word_d  = wr_word_q;
        idx_d      = idx_q;
        fresh_d    = sweep_q ? '0 : fresh_q;
        result_d   = result_q;
        wr_resp_d  = wr_resp_q;
        wr_ack_d   = 1'b0;
        sweep_d    = 1'b0;
        tmo_err_d  = tmo_err_q;
        w_gap_load = 1'b0;
        w_gap_val  = '0;

        if (!EN) begin
            // Abort without capture; poll position, fresh flags, the result
            // bank and the sticky error survive so EN=1 resumes the sweep.
            state_d    = c_ST_IDLE;
            data_in_d  = '0;
            is_write_d = 1'b0;
            wr_resp_d  = '0;
        end else begin
            case (state_q)
                c_ST_IDLE:   state_d = c_ST_SELECT;
                c_ST_SELECT: begin
                    is_write_d = WR_REQ;
                    if (WR_REQ) wr_word_d = WR_DATA;
                    state_d = c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    data_in_d = is_write_q ? wr_word_q : w_cmd_word;
                    state_d   = c_ST_START_HI;
                end
                c_ST_START_HI: if (w_gap_zero) state_d = c_ST_WAIT_BUSY;
                c_ST_WAIT_BUSY: begin
                    if (SPI_BUSY) begin
                        state_d = c_ST_WAIT_VALID;
                    end else if (w_tmo_zero) begin
                        tmo_err_d = 1'b1;
                        state_d   = c_ST_GAP;
                    end
                end
                c_ST_WAIT_VALID: begin
                    if (w_valid_rise) begin
                        if (is_write_q) begin
                            wr_resp_d = SPI_DATA_OUT;
                            wr_ack_d  = 1'b1;
                        end else begin
                            result_d[idx_q] = SPI_DATA_OUT;
                            fresh_d[idx_q]  = 1'b1;
                            idx_d           = w_idx_next;
                            sweep_d         = (idx_q == c_LAST_IDX);
                        end
                        state_d = c_ST_GAP;
                    end else if (w_tmo_zero) begin
                        tmo_err_d = 1'b1;
                        state_d   = c_ST_GAP;
                    end
                end
                c_ST_GAP: if (w_gap_zero) state_d = c_ST_SELECT;
                default:  state_d = c_ST_IDLE;
            endcase
        end

        // Timers are armed on state entry with (length - 1) so zero flags the
        // final cycle of the period.
        if ((state_d == c_ST_START_HI) && (state_q != c_ST_START_HI)) begin
            w_gap_load = 1'b1;
            w_gap_val  = c_GAP_W'(START_HOLD - 1);
        end else if ((state_d == c_ST_GAP) && (state_q != c_ST_GAP)) begin
            w_gap_load = 1'b1;
            w_gap_val  = c_GAP_W'(GAP_CYCLES - 1);
        end
        w_tmo_load = (state_d == c_ST_START_HI) && (state_q != c_ST_START_HI);

        // Registered so START is high exactly for the cycles spent in START_HI.
        start_d = (state_d == c_ST_START_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= c_ST_IDLE;
            start_q      <= 1'b0;
            data_in_q    <= '0;
            is_write_q   <= 1'b0;
            wr_word_q    <= '0;
            idx_q        <= '0;
            fresh_q      <= '0;
            wr_resp_q    <= '0;
            wr_ack_q     <= 1'b0;
            sweep_q      <= 1'b0;
            tmo_err_q    <= 1'b0;
            valid_prev_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) result_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            data_in_q    <= data_in_d;
            is_write_q   <= is_write_d;
            wr_word_q    <= wr_word_d;
            idx_q        <= idx_d;
            fresh_q      <= fresh_d;
            wr_resp_q    <= wr_resp_d;
            wr_ack_q     <= wr_ack_d;
            sweep_q      <= sweep_d;
            tmo_err_q    <= tmo_err_d;
            valid_prev_q <= SPI_VALID;
            result_q     <= result_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_result_flat
        assign RESULT_WORDS[gi*c_W +: c_W] = result_q[gi];
    end

    assign SPI_START    = start_q;
    assign SPI_DATA_IN  = data_in_q;
    assign WR_ACK       = wr_ack_q;
    assign WR_RESP      = wr_resp_q;
    assign RESULT_FRESH = fresh_q;
    assign SWEEP_DONE   = sweep_q;
    assign TIMEOUT_ERR  = tmo_err_q;

endmodule
`default_nettype wire
